// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample majority vote per bit,
// false-start rejection, and parity/framing/break reporting alongside each word.
module uart_rx_param #(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iRxSerial,
  output logic [DATA_BITS-1:0] oRxData,
  output logic                 oRxValid,
  output logic                 oParityErr,
  output logic                 oFrameErr,
  output logic                 oBreak,
  output logic                 oBusy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W = $clog2(DATA_BITS) + 1;
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S0    = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_S1    = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_DEC   = CNT_W'(HALF + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_WAIT_HIGH, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    return (PARITY == 2) ? ~x : x;
  endfunction

  state_t                 state, stateNext;
  logic                   syncMeta, rx;
  logic [CNT_W-1:0]       baudCnt;
  logic [BIT_W-1:0]       bitCnt;
  logic [1:0]             samp;
  logic [DATA_BITS-1:0]   shiftReg;
  logic                   parityErr, frameErr, allZero;
  logic                   decide, vote;

  // Synchroniser stage: idle-high so reset never looks like a start edge
  always_ff @(posedge iClk) begin
    if (iRst) begin
      syncMeta <= 1'b1;
      rx       <= 1'b1;
    end else begin
      syncMeta <= iRxSerial;
      rx       <= syncMeta;
    end
  end

  // The third vote sample is the live rx, so the decision lands at centre+1
  assign decide = (baudCnt == CNT_DEC);
  assign vote   = majority3(samp[1], samp[0], rx);
  assign oBusy  = (state != S_IDLE) && (state != S_WAIT_HIGH);

  always_ff @(posedge iClk) begin
    if (iRst) state <= S_WAIT_HIGH;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_WAIT_HIGH: if (rx) stateNext = S_IDLE;
      S_IDLE:      if (!rx) stateNext = S_START;
      S_START:     if (decide) stateNext = vote ? S_IDLE : S_DATA;
      S_DATA:      if (decide && bitCnt == DATA_LAST)
                     stateNext = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (decide) stateNext = S_STOP;
      S_STOP:      if (decide && bitCnt == STOP_LAST) stateNext = S_DONE;
      S_DONE:      stateNext = allZero ? S_WAIT_HIGH : S_IDLE;
      default:     stateNext = S_WAIT_HIGH;
    endcase
  end

  // Bit timing stage: baudCnt counts cycles since the current bit boundary
  always_ff @(posedge iClk) begin
    if (iRst) begin
      baudCnt <= '0;
      bitCnt  <= '0;
    end else begin
      if (state == S_IDLE || state == S_WAIT_HIGH)
        baudCnt <= CNT_W'(1);
      else
        baudCnt <= (baudCnt == CNT_LAST) ? '0 : baudCnt + 1'b1;
      if (decide)
        bitCnt <= (stateNext != state) ? '0 : bitCnt + 1'b1;
    end
  end

  // Sample and accumulate stage
  always_ff @(posedge iClk) begin
    if (baudCnt == CNT_S0 || baudCnt == CNT_S1)
      samp <= {samp[0], rx};
    if (decide) begin
      case (state)
        S_START: begin
          allZero   <= 1'b1;
          parityErr <= 1'b0;
          frameErr  <= 1'b0;
        end
        S_DATA: begin
          shiftReg <= {vote, shiftReg[DATA_BITS-1:1]};
          allZero  <= allZero & ~vote;
        end
        S_PARITY: begin
          parityErr <= parity_error(shiftReg, vote);
          allZero   <= allZero & ~vote;
        end
        S_STOP: begin
          if (!vote) frameErr <= 1'b1;
          allZero <= allZero & ~vote;
        end
        default: ;
      endcase
    end
  end

  // Output stage: word and flags change together with the valid pulse
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oRxData    <= '0;
      oRxValid   <= 1'b0;
      oParityErr <= 1'b0;
      oFrameErr  <= 1'b0;
      oBreak     <= 1'b0;
    end else begin
      oRxValid <= (state == S_DONE);
      if (state == S_DONE) begin
        oRxData    <= shiftReg;
        oParityErr <= (PARITY != 0) && parityErr;
        oFrameErr  <= frameErr;
        oBreak     <= allZero;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1, 8E1, 7O2) at 16 clocks/bit,
// checked against a frame-level model of expected words, flags and pulse times.
module tb_uart_rx_param;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  typedef struct packed {
    logic [31:0] cyc;
    logic [8:0]  data;
    logic        pe;
    logic        fe;
    logic        brk;
  } rec_t;

  int cfgBits [3] = '{8, 8, 7};
  int cfgPar  [3] = '{0, 1, 2};
  int cfgStop [3] = '{1, 1, 2};

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lineA = 1'b1, lineB = 1'b1, lineC = 1'b1;
  logic [7:0] dA, dB;
  logic [6:0] dC;
  logic vA, peA, feA, brkA, busyA;
  logic vB, peB, feB, brkB, busyB;
  logic vC, peC, feC, brkC, busyC;

  rec_t qA[$], qB[$], qC[$];

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
    .iClk(clk), .iRst(rst), .iRxSerial(lineA), .oRxData(dA), .oRxValid(vA),
    .oParityErr(peA), .oFrameErr(feA), .oBreak(brkA), .oBusy(busyA));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dutB (
    .iClk(clk), .iRst(rst), .iRxSerial(lineB), .oRxData(dB), .oRxValid(vB),
    .oParityErr(peB), .oFrameErr(feB), .oBreak(brkB), .oBusy(busyB));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dutC (
    .iClk(clk), .iRst(rst), .iRxSerial(lineC), .oRxData(dC), .oRxValid(vC),
    .oParityErr(peC), .oFrameErr(feC), .oBreak(brkC), .oBusy(busyC));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t mk(input int c, input logic [8:0] d, input logic pe,
                              input logic fe, input logic brk);
    rec_t r;
    r.cyc = 32'(c); r.data = d; r.pe = pe; r.fe = fe; r.brk = brk;
    return r;
  endfunction

  always @(negedge clk) begin
    if (vA === 1'b1) qA.push_back(mk(cyc, {1'b0, dA}, peA, feA, brkA));
    if (vB === 1'b1) qB.push_back(mk(cyc, {1'b0, dB}, peB, feB, brkB));
    if (vC === 1'b1) qC.push_back(mk(cyc, {2'b0, dC}, peC, feC, brkC));
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  function automatic string fmt(input rec_t r);
    return $sformatf("cyc=%0d data=%h pe=%b fe=%b brk=%b", r.cyc, r.data, r.pe, r.fe, r.brk);
  endfunction

  function automatic int nframe(input int id);
    return 1 + cfgBits[id] + ((cfgPar[id] != 0) ? 1 : 0) + cfgStop[id];
  endfunction

  // pMode: 0 = correct parity bit, 1 = force 0, 2 = force 1
  function automatic logic par_bit(input int id, input logic [8:0] data, input int pMode);
    int ones;
    ones = 0;
    if (pMode == 1) return 1'b0;
    if (pMode == 2) return 1'b1;
    for (int i = 0; i < cfgBits[id]; i++) ones += int'(data[i]);
    return (cfgPar[id] == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  function automatic rec_t expect_rec(input int id, input logic [8:0] data, input int pMode,
                                      input bit stopLow, input int startCyc);
    rec_t e;
    logic [8:0] d;
    logic pb;
    d     = data & 9'((1 << cfgBits[id]) - 1);
    pb    = par_bit(id, d, pMode);
    e.cyc = 32'(startCyc + 2 + HALF + (nframe(id) - 1) * CPB + 3);
    e.data = d;
    e.pe  = (cfgPar[id] != 0) && (pb != par_bit(id, d, 0));
    e.fe  = stopLow;
    e.brk = (d == 9'd0) && stopLow && (cfgPar[id] == 0 || pb == 1'b0);
    return e;
  endfunction

  task automatic set_line(input int id, input logic v);
    case (id)
      0:       lineA = v;
      1:       lineB = v;
      default: lineC = v;
    endcase
  endtask

  function automatic int qcount(input int id);
    case (id)
      0:       return qA.size();
      1:       return qB.size();
      default: return qC.size();
    endcase
  endfunction

  task automatic get_rec(input int id, output bit ok, output rec_t r);
    ok = 1'b0;
    r  = '0;
    case (id)
      0: if (qA.size() > 0) begin r = qA.pop_front(); ok = 1'b1; end
      1: if (qB.size() > 0) begin r = qB.pop_front(); ok = 1'b1; end
      default: if (qC.size() > 0) begin r = qC.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Drives one frame starting at the current negedge; stopAt >= 0 abandons it mid-frame.
  task automatic send_frame(input int id, input logic [8:0] data, input int pMode,
                            input bit stopLow, input int gBit, input int gOff,
                            input int stopAt, output int startCyc);
    logic bits [0:15];
    int n;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < cfgBits[id]; i++) begin bits[n] = data[i]; n++; end
    if (cfgPar[id] != 0) begin bits[n] = par_bit(id, data, pMode); n++; end
    for (int i = 0; i < cfgStop[id]; i++) begin bits[n] = ~stopLow; n++; end
    startCyc = cyc;
    for (int j = 0; j < n; j++) begin
      for (int o = 0; o < CPB; o++) begin
        if (stopAt >= 0 && j * CPB + o == stopAt) return;
        set_line(id, bits[j] ^ ((j == gBit) && (o == gOff)));
        @(negedge clk);
      end
    end
    set_line(id, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nTests++;
    if ({dA, vA, peA, feA, brkA, busyA} !== 13'd0) begin
      nFail++; $display("FAIL reset_A: got %b, expected all zero", {dA, vA, peA, feA, brkA, busyA});
    end
    nTests++;
    if ({dB, vB, peB, feB, brkB, busyB} !== 13'd0) begin
      nFail++; $display("FAIL reset_B: got %b, expected all zero", {dB, vB, peB, feB, brkB, busyB});
    end
    nTests++;
    if ({dC, vC, peC, feC, brkC, busyC} !== 12'd0) begin
      nFail++; $display("FAIL reset_C: got %b, expected all zero", {dC, vC, peC, feC, brkC, busyC});
    end
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    nTests++;
    if ({busyA, busyB, busyC} !== 3'b000 || qA.size() + qB.size() + qC.size() != 0) begin
      nFail++; $display("FAIL idle_after_reset: busy=%b pulses=%0d, expected busy=000 pulses=0",
                        {busyA, busyB, busyC}, qA.size() + qB.size() + qC.size());
    end
  endtask

  task automatic test_8n1_clean();
    int s; bit ok; rec_t r, e;
    send_frame(0, 9'h0A5, 0, 1'b0, -1, 0, -1, s);
    repeat (CPB) @(negedge clk);
    e = expect_rec(0, 9'h0A5, 0, 1'b0, s);
    get_rec(0, ok, r);
    nTests++;
    if (!ok || r !== e) begin
      nFail++; $display("FAIL 8n1_clean: got %s, expected %s", ok ? fmt(r) : "no pulse", fmt(e));
    end
    nTests++;
    if (dA !== 8'hA5 || qcount(0) != 0) begin
      nFail++; $display("FAIL 8n1_hold: data=%h extra=%0d, expected data=a5 extra=0", dA, qcount(0));
    end
  endtask

  task automatic test_parity();
    int s0, s1; bit ok; rec_t r, e;
    send_frame(1, 9'h037, 1, 1'b0, -1, 0, -1, s0);
    send_frame(1, 9'h037, 2, 1'b0, -1, 0, -1, s1);
    repeat (CPB) @(negedge clk);
    e = expect_rec(1, 9'h037, 1, 1'b0, s0);
    get_rec(1, ok, r);
    nTests++;
    if (!ok || r !== e) begin
      nFail++; $display("FAIL parity_bad: got %s, expected %s", ok ? fmt(r) : "no pulse", fmt(e));
    end
    e = expect_rec(1, 9'h037, 2, 1'b0, s1);
    get_rec(1, ok, r);
    nTests++;
    if (!ok || r !== e) begin
      nFail++; $display("FAIL parity_good: got %s, expected %s", ok ? fmt(r) : "no pulse", fmt(e));
    end
  endtask

  task automatic test_glitches();
    int s; bit ok; rec_t r, e;
    s = cyc;
    lineA = 1'b0;
    repeat (3) @(negedge clk);
    lineA = 1'b1;
    while (cyc < s + 4) @(negedge clk);
    nTests++;
    if (busyA !== 1'b1) begin
      nFail++; $display("FAIL false_start_busy_hi: got busy=%b, expected 1", busyA);
    end
    while (cyc < s + 2 + HALF + 2) @(negedge clk);
    nTests++;
    if (busyA !== 1'b0) begin
      nFail++; $display("FAIL false_start_release: got busy=%b at c0+2, expected 0", busyA);
    end
    repeat (12 * CPB) @(negedge clk);
    nTests++;
    if (qcount(0) != 0) begin
      nFail++; $display("FAIL false_start_quiet: got %0d pulses, expected 0", qcount(0));
      qA.delete();
    end
    send_frame(0, 9'h05A, 0, 1'b0, 3, HALF, -1, s);
    repeat (CPB) @(negedge clk);
    e = expect_rec(0, 9'h05A, 0, 1'b0, s);
    get_rec(0, ok, r);
    nTests++;
    if (!ok || r !== e) begin
      nFail++; $display("FAIL data_glitch: got %s, expected %s", ok ? fmt(r) : "no pulse", fmt(e));
    end
    send_frame(0, 9'h05A, 0, 1'b0, 0, HALF - 1, -1, s);
    repeat (CPB) @(negedge clk);
    e = expect_rec(0, 9'h05A, 0, 1'b0, s);
    get_rec(0, ok, r);
    nTests++;
    if (!ok || r !== e) begin
      nFail++; $display("FAIL start_glitch: got %s, expected %s", ok ? fmt(r) : "no pulse", fmt(e));
    end
  endtask

  task automatic test_frame_err();
    int s; bit ok; rec_t r, e;
    send_frame(0, 9'h0C3, 0, 1'b1, -1, 0, -1, s);
    repeat (3 * CPB) @(negedge clk);
    e = expect_rec(0, 9'h0C3, 0, 1'b1, s);
    get_rec(0, ok, r);
    nTests++;
    if (!ok || r !== e) begin
      nFail++; $display("FAIL frame_err: got %s, expected %s", ok ? fmt(r) : "no pulse", fmt(e));
    end
  endtask

  task automatic test_break();
    int s; bit ok; rec_t r, e;
    s = cyc;
    lineA = 1'b0;
    repeat (15 * CPB) @(negedge clk);
    nTests++;
    if (busyA !== 1'b0) begin
      nFail++; $display("FAIL break_wait_high: got busy=%b while line low, expected 0", busyA);
    end
    repeat (5 * CPB) @(negedge clk);
    nTests++;
    if (qcount(0) != 1) begin
      nFail++; $display("FAIL break_count: got %0d pulses, expected 1", qcount(0));
    end
    e = expect_rec(0, 9'h000, 0, 1'b1, s);
    get_rec(0, ok, r);
    nTests++;
    if (!ok || r !== e) begin
      nFail++; $display("FAIL break_frame: got %s, expected %s", ok ? fmt(r) : "no pulse", fmt(e));
    end
    qA.delete();
    lineA = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    nTests++;
    if (qcount(0) != 0) begin
      nFail++; $display("FAIL break_release: got %0d pulses, expected 0", qcount(0));
      qA.delete();
    end
    send_frame(0, 9'h011, 0, 1'b0, -1, 0, -1, s);
    repeat (CPB) @(negedge clk);
    e = expect_rec(0, 9'h011, 0, 1'b0, s);
    get_rec(0, ok, r);
    nTests++;
    if (!ok || r !== e) begin
      nFail++; $display("FAIL after_break: got %s, expected %s", ok ? fmt(r) : "no pulse", fmt(e));
    end
  endtask

  task automatic test_7o2_reset();
    int s; bit ok; rec_t r, e;
    send_frame(2, 9'h041, 0, 1'b0, -1, 0, -1, s);
    repeat (CPB) @(negedge clk);
    e = expect_rec(2, 9'h041, 0, 1'b0, s);
    get_rec(2, ok, r);
    nTests++;
    if (!ok || r !== e) begin
      nFail++; $display("FAIL 7o2_clean: got %s, expected %s", ok ? fmt(r) : "no pulse", fmt(e));
    end
    send_frame(2, 9'h055, 0, 1'b0, -1, 0, 4 * CPB + 5, s);
    nTests++;
    if (busyC !== 1'b1) begin
      nFail++; $display("FAIL mid_frame_busy: got busy=%b, expected 1", busyC);
    end
    rst = 1'b1;
    @(negedge clk);
    nTests++;
    if ({dC, vC, peC, feC, brkC, busyC} !== 12'd0) begin
      nFail++; $display("FAIL mid_frame_reset: got %b, expected all zero", {dC, vC, peC, feC, brkC, busyC});
    end
    rst = 1'b0;
    lineC = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    nTests++;
    if (qcount(2) != 0) begin
      nFail++; $display("FAIL reset_no_pulse: got %0d pulses, expected 0", qcount(2));
      qC.delete();
    end
    send_frame(2, 9'h02A, 0, 1'b0, -1, 0, -1, s);
    repeat (CPB) @(negedge clk);
    e = expect_rec(2, 9'h02A, 0, 1'b0, s);
    get_rec(2, ok, r);
    nTests++;
    if (!ok || r !== e) begin
      nFail++; $display("FAIL after_reset: got %s, expected %s", ok ? fmt(r) : "no pulse", fmt(e));
    end
  endtask

  // Random frames sent back to back, with random parity, stop faults and single-sample glitches
  task automatic test_random();
    for (int id = 0; id < 3; id++) begin
      rec_t expQ[$];
      bit ok; rec_t r, e;
      int s, pMode, gBit, gOff;
      bit stopLow;
      logic [8:0] data;
      for (int f = 0; f < 12; f++) begin
        data    = 9'($urandom);
        pMode   = int'($urandom_range(0, 2));
        stopLow = ($urandom_range(0, 7) == 0);
        gBit    = -1;
        gOff    = 0;
        if ($urandom_range(0, 1) == 1) begin
          gBit = int'($urandom_range(0, nframe(id) - 1));
          gOff = HALF - 1 + int'($urandom_range(0, 2));
        end
        send_frame(id, data, pMode, stopLow, gBit, gOff, -1, s);
        expQ.push_back(expect_rec(id, data, pMode, stopLow, s));
        if (stopLow) repeat (2 * CPB) @(negedge clk);
      end
      repeat (2 * CPB) @(negedge clk);
      foreach (expQ[k]) begin
        e = expQ[k];
        get_rec(id, ok, r);
        nTests++;
        if (!ok || r !== e) begin
          nFail++; $display("FAIL random_%0d_%0d: got %s, expected %s", id, k, ok ? fmt(r) : "no pulse", fmt(e));
        end
      end
      nTests++;
      if (qcount(id) != 0) begin
        nFail++; $display("FAIL random_%0d_extra: got %0d extra pulses, expected 0", id, qcount(id));
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1_clean();
    test_parity();
    test_glitches();
    test_frame_err();
    test_break();
    test_7o2_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the next generation of the team's fixed 8N1 receiver. It supports configurable data width, parity mode and stop-bit count. It adds three behaviours the 8N1 block lacks: 3-sample majority voting at each bit centre, rejection of false start bits, and parity, framing and break reporting. It sits between the board's serial RX pin and the byte-stream consumer, such as a command parser or RX FIFO, all in the single `iClk` domain.

## Interface
- `CLK_FREQ`, default 125_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in baud.
- `CLKS_PER_BIT`, default CLK_FREQ/BAUD_RATE (1085): clocks per bit. Must be ≥ 8.
- `DATA_BITS`, default 8: data bits per frame, legal 5..9, sent LSB first.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: legal 1 or 2.

Ports (name, direction, width, meaning):
- `iClk` in 1: sole clock.
- `iRst` in 1: synchronous, active-high reset.
- `iRxSerial` in 1: asynchronous serial line, idle high.
- `oRxData` out DATA_BITS: last received word, held until the next `oRxValid`.
- `oRxValid` out 1: one-cycle pulse, frame complete.
- `oParityErr` out 1: parity mismatch on the last frame. Updated with `oRxValid`; always 0 when PARITY = 0.
- `oFrameErr` out 1: a stop bit was sampled low on the last frame. Updated with `oRxValid`.
- `oBreak` out 1: last frame was a break (all sampled bits low). Updated with `oRxValid`.
- `oBusy` out 1: high in every state except IDLE and WAIT_HIGH.

## Operation
- **Synchroniser:** `iRxSerial` passes through a 2-FF synchroniser (both FFs reset to 1). All logic below uses the synchronised line `rx`.
- **Frame geometry:** NFRAME = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS. HALF = CLKS_PER_BIT/2, using integer division.
- **Bit sampling:** each bit is decided by a majority of three `rx` samples at cycles c−1, c and c+1, where c is the bit centre.
- **States:** WAIT_HIGH, IDLE, START, DATA, PARITY, STOP, DONE.
  - **WAIT_HIGH (reset state):** go to IDLE on the first cycle `rx` = 1. This prevents a line held low at reset from being decoded.
  - **IDLE:** on `rx` = 0, record that cycle as T0 and go to START.
  - **START:** vote the start bit at centre c0 = T0 + HALF.
    - Vote 1 means a false start: return to IDLE with no output.
    - Vote 0 goes to DATA.
  - **DATA:** bit k (0..DATA_BITS−1) has centre T0 + HALF + (1+k)·CLKS_PER_BIT and is shifted in LSB first.
  - **PARITY** (only when PARITY≠0): vote the parity bit p.
    - Even mode: error if XOR(data) ^ p = 1.
    - Odd mode: error if XOR(data) ^ p = 0.
  - **STOP:** vote each stop bit. Any stop vote of 0 sets the frame-error result.
  - **DONE:** register data and flags, then pulse `oRxValid`.
    - Break: if every voted bit in the frame (start, data, parity, stops) was 0, set `oBreak` and go to WAIT_HIGH.
    - Otherwise go to IDLE.
- **Early exit:** the receiver does not wait for the end of the last stop bit. It re-arms after the last stop-bit centre, giving a +½-bit resync margin.
- **Error frames:** data is still delivered on a parity error or framing error. The flags describe only the frame just delivered.
- **Counters:** the baud counter is $clog2(CLKS_PER_BIT)+1 bits and resets to 0 at each bit boundary. The bit counter is $clog2(DATA_BITS)+1 bits. Neither counter may wrap inside a bit.

## Timing
- **Reset values:** all outputs 0, `oRxData` = 0, state = WAIT_HIGH, synchroniser = 1.
- **Latency:** `iRxSerial` to `rx` is 2 cycles. T0 is defined on `rx`.
- **Bit decision:** the vote for centre c is available at c+2.
- **Valid pulse:** `oRxValid` is high for exactly one cycle, at T0 + HALF + (NFRAME−1)·CLKS_PER_BIT + 3. `oRxData` and all flags change on that same cycle.
- **Back-to-back frames:** a new start edge is accepted from the cycle after DONE.
- **False start:** a low glitch shorter than HALF−1 cycles produces no output. Control returns to IDLE by c0 + 2.
- **Reset mid-frame:** `iRst` high on any cycle gives reset values on the next cycle, with no `oRxValid` for the partial frame.
- **Single-sample glitch:** a one-sample inverted glitch at any bit centre does not change the voted bit.

## Test plan
1. **8N1 clean frame:** CLKS_PER_BIT = 16, 8N1, send 0xA5 -> one `oRxValid` at T0+8+9·16+3, `oRxData` = 0xA5, all flags 0.
2. **Parity error:** PARITY = 1 (even), send 0x37 (five ones) with parity bit 0 -> `oRxData` = 0x37, `oParityErr` = 1. The same frame with parity bit 1 gives `oParityErr` = 0.
3. **Start and sampling glitches:** a 3-cycle low glitch on an idle line -> no `oRxValid`, `oBusy` back to 0 by c0+2. A 1-cycle glitch at a data-bit centre of 0x5A -> `oRxData` = 0x5A.
4. **Framing error:** send 0xC3 with the stop bit driven low -> `oRxData` = 0xC3, `oFrameErr` = 1, `oBreak` = 0.
5. **Break:** hold the line low for 20 bit times, then high -> exactly one `oRxValid` with `oRxData` = 0, `oBreak` = 1, `oFrameErr` = 1. No further pulses until the line returns high and a new 0x11 frame is received correctly.
6. **7O2 and reset:** DATA_BITS = 7, PARITY = 2 (odd), STOP_BITS = 2, send 0x41 -> `oRxData` = 0x41, no errors. Then assert `iRst` mid-data-bit -> no `oRxValid`, all outputs 0 next cycle, and a following frame 0x2A is received correctly.
